// File: rtl/jtpopeye_sdram_pkg.sv
// Shared types and helpers for the SDRAM ROM arbiter: FSM states, slot index width
// and the default per-slot base offset.
package jtpopeye_sdram_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} sdram_st_e;

  // One bit of the default BASE vector; replicated to SLOTS*AW bits by the top.
  localparam logic BASE_DEF_BIT = 1'b0;

  // Width of a slot index; a single slot still needs one bit to hold index 0.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/jtpopeye_sdram_slot.sv
// One-word read cache for a single ROM client: tag, data and valid bit,
// with a same-cycle hit compare against the client's current address.
module jtpopeye_sdram_slot
  import jtpopeye_sdram_pkg::*;
#(
  parameter int SAW = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           load,
  input  logic [SAW-1:0] load_tag,
  input  logic [31:0]    load_data,
  input  logic           cs,
  input  logic [SAW-1:0] addr,
  output logic [31:0]    dout,
  output logic           ok
);

  logic           valid;
  logic [SAW-1:0] tag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
      dout  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      tag   <= load_tag;
      dout  <= load_data;
    end
  end

  assign ok = cs && valid && (tag == addr);

endmodule

// File: rtl/jtpopeye_sdram_mux.sv
// Round-robin SDRAM ROM arbiter with a one-word cache per client; also produces
// refresh_en for the controller and a delayed ready once the ROM download ends.
module jtpopeye_sdram_mux
  import jtpopeye_sdram_pkg::*;
#(
  parameter int                   SLOTS   = 4,
  parameter int                   AW      = 22,
  parameter int                   SAW     = 15,
  parameter logic [SLOTS*AW-1:0]  BASE    = {(SLOTS*AW){BASE_DEF_BIT}},
  parameter int                   RDY_DLY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 downloading,
  input  logic [SLOTS-1:0]     slot_cs,
  input  logic [SLOTS*SAW-1:0] slot_addr,
  output logic [SLOTS*32-1:0]  slot_dout,
  output logic [SLOTS-1:0]     slot_ok,
  output logic                 sdram_req,
  output logic [AW-1:0]        sdram_addr,
  input  logic                 sdram_ack,
  input  logic                 data_rdy,
  input  logic [31:0]          data_read,
  output logic                 refresh_en,
  output logic                 ready
);

  localparam int IW = idx_w(SLOTS);

  sdram_st_e      st, st_nxt;
  logic [IW-1:0]  ptr, ptr_nxt, gnt, gnt_nxt, gsel, gnt_inc;
  logic [SAW-1:0] lat_addr, lat_addr_nxt, gsel_addr;
  logic           req_nxt, store, any_miss;
  logic [AW-1:0]  addr_nxt;
  logic [SLOTS-1:0] cs_eff, miss, load;
  logic [3:0]     rdy_cnt;

  // The loader owns the SDRAM while downloading, so client requests are dropped.
  assign cs_eff = slot_cs & ~{SLOTS{downloading}};

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    assign miss[i] = cs_eff[i] && !slot_ok[i] &&
                     !(st != IDLE && gnt == IW'(i) && lat_addr == slot_addr[i*SAW +: SAW]);
    assign load[i] = store && (gnt == IW'(i));

    jtpopeye_sdram_slot #(.SAW(SAW)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (downloading),
      .load      (load[i]),
      .load_tag  (lat_addr),
      .load_data (data_read),
      .cs        (cs_eff[i]),
      .addr      (slot_addr[i*SAW +: SAW]),
      .dout      (slot_dout[i*32 +: 32]),
      .ok        (slot_ok[i])
    );
  end

  // First missing slot at or after ptr, wrapping around.
  always_comb begin
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    gsel  = ptr;
    for (int k = 0; k < SLOTS; k++) begin
      idx = (int'(ptr) + k) % SLOTS;
      if (!found && miss[idx]) begin
        found = 1'b1;
        gsel  = IW'(idx);
      end
    end
    any_miss  = |miss;
    gsel_addr = slot_addr[int'(gsel)*SAW +: SAW];
    gnt_inc   = (int'(gnt) + 1 == SLOTS) ? '0 : gnt + 1'b1;
  end

  always_comb begin
    st_nxt       = st;
    ptr_nxt      = ptr;
    gnt_nxt      = gnt;
    lat_addr_nxt = lat_addr;
    req_nxt      = sdram_req;
    addr_nxt     = sdram_addr;
    store        = 1'b0;
    if (downloading) begin
      st_nxt  = IDLE;
      req_nxt = 1'b0;
    end else begin
      case (st)
        IDLE: if (any_miss) begin
          gnt_nxt      = gsel;
          lat_addr_nxt = gsel_addr;
          addr_nxt     = BASE[int'(gsel)*AW +: AW] + AW'(gsel_addr);
          req_nxt      = 1'b1;
          st_nxt       = REQ;
        end
        REQ: if (sdram_ack) begin
          req_nxt = 1'b0;
          // Data may arrive together with the ack; accept it rather than wait forever.
          if (data_rdy) begin
            store   = 1'b1;
            ptr_nxt = gnt_inc;
            st_nxt  = IDLE;
          end else begin
            st_nxt  = WAIT;
          end
        end
        WAIT: if (data_rdy) begin
          store   = 1'b1;
          ptr_nxt = gnt_inc;
          st_nxt  = IDLE;
        end
        default: st_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st         <= IDLE;
      ptr        <= '0;
      gnt        <= '0;
      lat_addr   <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
    end else begin
      st         <= st_nxt;
      ptr        <= ptr_nxt;
      gnt        <= gnt_nxt;
      lat_addr   <= lat_addr_nxt;
      sdram_req  <= req_nxt;
      sdram_addr <= addr_nxt;
    end
  end

  assign refresh_en = (st == IDLE) && !any_miss && !downloading;

  always_ff @(posedge clk) begin
    if (!rst_n || downloading) begin
      rdy_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      if (rdy_cnt != 4'(RDY_DLY)) rdy_cnt <= rdy_cnt + 4'd1;
      if (rdy_cnt == 4'(RDY_DLY)) ready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtpopeye_sdram_mux.sv
// Directed bench for jtpopeye_sdram_mux: four slots, distinct base offsets, hand-computed expectations.
module tb_jtpopeye_sdram_mux;

  localparam int SLOTS = 4;
  localparam int AW    = 22;
  localparam int SAW   = 15;
  localparam logic [SLOTS*AW-1:0] BASE = {22'h4000, 22'h3000, 22'h2000, 22'h1000};

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 downloading = 1'b0;
  logic [SLOTS-1:0]     slot_cs = '0;
  logic [SLOTS*SAW-1:0] slot_addr = '0;
  logic [SLOTS*32-1:0]  slot_dout;
  logic [SLOTS-1:0]     slot_ok;
  logic                 sdram_req;
  logic [AW-1:0]        sdram_addr;
  logic                 sdram_ack = 1'b0;
  logic                 data_rdy = 1'b0;
  logic [31:0]          data_read = '0;
  logic                 refresh_en;
  logic                 ready;

  int checks = 0;
  int failures = 0;

  jtpopeye_sdram_mux #(
    .SLOTS(SLOTS), .AW(AW), .SAW(SAW), .BASE(BASE), .RDY_DLY(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .downloading(downloading),
    .slot_cs    (slot_cs),
    .slot_addr  (slot_addr),
    .slot_dout  (slot_dout),
    .slot_ok    (slot_ok),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .data_rdy   (data_rdy),
    .data_read  (data_read),
    .refresh_en (refresh_en),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dout(input int i);
    return slot_dout[i*32 +: 32];
  endfunction

  task automatic set_addr(input int i, input logic [SAW-1:0] a);
    slot_addr[i*SAW +: SAW] = a;
  endtask

  task automatic wait_req(input string tag, input logic [AW-1:0] exp_addr);
    int n;
    n = 0;
    while (!sdram_req && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req"}, sdram_req, 1'b1);
    check({tag, "_addr"}, sdram_addr, exp_addr);
  endtask

  // Full miss service: ack one cycle, one idle cycle, then data for one cycle.
  task automatic serve(input string tag, input logic [AW-1:0] exp_addr, input logic [31:0] d);
    wait_req(tag, exp_addr);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    tick();
    data_read = d;
    data_rdy  = 1'b1;
    tick();
    data_rdy  = 1'b0;
    data_read = '0;
    #1;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_req", sdram_req, 1'b0);
    check("rst_addr", sdram_addr, '0);
    check("rst_dout", slot_dout, '0);
    check("rst_ok", slot_ok, '0);
    check("rst_ready", ready, 1'b0);
    check("rst_refresh", refresh_en, 1'b1);

    // Download end and ready delay
    rst_n = 1'b1;
    downloading = 1'b1;
    tick(); tick();
    check("dl_ready", ready, 1'b0);
    check("dl_refresh", refresh_en, 1'b0);
    downloading = 1'b0;
    tick();
    check("rdy_c1", ready, 1'b0);
    tick();
    check("rdy_c2", ready, 1'b0);
    tick();
    check("rdy_c3", ready, 1'b1);
    check("idle_refresh", refresh_en, 1'b1);

    // Single miss on slot 0, slow ack and data
    slot_cs[0] = 1'b1;
    set_addr(0, 15'h0010);
    #1;
    check("m0_ok_pre", slot_ok[0], 1'b0);
    check("m0_refresh", refresh_en, 1'b0);
    tick();
    check("m0_req", sdram_req, 1'b1);
    check("m0_addr", sdram_addr, 22'h001010);
    tick(); tick();
    check("m0_req_hold", sdram_req, 1'b1);
    check("m0_addr_hold", sdram_addr, 22'h001010);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    #1;
    check("m0_req_drop", sdram_req, 1'b0);
    tick(); tick(); tick();
    data_read = 32'hDEADBEEF;
    data_rdy  = 1'b1;
    #1;
    check("m0_ok_wait", slot_ok[0], 1'b0);
    tick();
    data_rdy  = 1'b0;
    data_read = '0;
    #1;
    check("m0_ok", slot_ok[0], 1'b1);
    check("m0_dout", dout(0), 32'hDEADBEEF);
    check("m0_refresh_after", refresh_en, 1'b1);
    tick();
    check("m0_noreq", sdram_req, 1'b0);
    slot_cs[0] = 1'b0;
    tick();
    slot_cs[0] = 1'b1;
    #1;
    check("hit_ok", slot_ok[0], 1'b1);
    tick();
    check("hit_noreq", sdram_req, 1'b0);

    // Round-robin order from ptr=0, then from ptr=3
    rst_n = 1'b0;
    slot_cs = '0;
    tick();
    rst_n = 1'b1;
    slot_cs = 4'b0111;
    set_addr(0, 15'h20);
    set_addr(1, 15'h21);
    set_addr(2, 15'h22);
    serve("rr0", 22'h001020, 32'h00000A00);
    check("rr0_ok", slot_ok, 4'b0001);
    serve("rr1", 22'h002021, 32'h00000A01);
    check("rr1_ok", slot_ok, 4'b0011);
    serve("rr2", 22'h003022, 32'h00000A02);
    check("rr2_ok", slot_ok, 4'b0111);
    check("rr2_dout1", dout(1), 32'h00000A01);
    set_addr(0, 15'h30);
    set_addr(2, 15'h32);
    serve("rr3", 22'h001030, 32'hA0A0A0A0);
    serve("rr4", 22'h003032, 32'hC2C2C2C2);
    check("rr4_ok", slot_ok, 4'b0111);
    check("rr4_dout0", dout(0), 32'hA0A0A0A0);
    check("rr4_dout2", dout(2), 32'hC2C2C2C2);

    // Address change during WAIT keeps the latched tag
    slot_cs = 4'b0010;
    set_addr(1, 15'h05);
    wait_req("ac", 22'h002005);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    set_addr(1, 15'h06);
    #1;
    check("ac_ok_wait", slot_ok[1], 1'b0);
    data_read = 32'h55555555;
    data_rdy  = 1'b1;
    tick();
    data_rdy  = 1'b0;
    data_read = '0;
    #1;
    check("ac_ok_new", slot_ok[1], 1'b0);
    check("ac_noreq", sdram_req, 1'b0);
    set_addr(1, 15'h05);
    #1;
    check("ac_tag_old", slot_ok[1], 1'b1);
    check("ac_dout_old", dout(1), 32'h55555555);
    set_addr(1, 15'h06);
    #1;
    serve("ac_re", 22'h002006, 32'h66666666);
    check("ac_re_ok", slot_ok[1], 1'b1);
    check("ac_re_dout", dout(1), 32'h66666666);

    // Download pulse during WAIT
    slot_cs = 4'b0011;
    set_addr(0, 15'h40);
    #1;
    check("dp_hit_pre", slot_ok[1], 1'b1);
    wait_req("dp", 22'h001040);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    downloading = 1'b1;
    tick();
    downloading = 1'b0;
    #1;
    check("dp_req", sdram_req, 1'b0);
    check("dp_ok", slot_ok, 4'b0000);
    check("dp_ready", ready, 1'b0);
    data_read = 32'hBAD0BAD0;
    data_rdy  = 1'b1;
    tick();
    data_rdy  = 1'b0;
    data_read = '0;
    #1;
    check("dp_ign_ok", slot_ok[0], 1'b0);
    check("dp_ign_dout", dout(0), 32'hA0A0A0A0);
    serve("dp_rf0", 22'h001040, 32'h40404040);
    serve("dp_rf1", 22'h002006, 32'h60606060);
    check("dp_rf_ok", slot_ok, 4'b0011);
    check("dp_rf_dout0", dout(0), 32'h40404040);
    check("dp_rf_dout1", dout(1), 32'h60606060);

    // Ack and data in the same cycle
    slot_cs = 4'b0100;
    set_addr(2, 15'h77);
    wait_req("ad", 22'h003077);
    sdram_ack = 1'b1;
    data_rdy  = 1'b1;
    data_read = 32'h12345678;
    tick();
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    data_read = '0;
    #1;
    check("ad_req", sdram_req, 1'b0);
    check("ad_ok", slot_ok[2], 1'b1);
    check("ad_dout", dout(2), 32'h12345678);
    check("ad_refresh", refresh_en, 1'b1);
    set_addr(2, 15'h78);
    serve("ad_next", 22'h003078, 32'h87654321);
    check("ad_next_ok", slot_ok[2], 1'b1);
    check("ad_next_dout", dout(2), 32'h87654321);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtpopeye_sdram_mux.md
Name: jtpopeye_sdram_mux

Overview:
Parametrised SDRAM ROM arbiter for game tops. It replaces the fixed main/obj ROM fetcher with SLOTS independent read clients. Each client has a one-word cache (tag + data), so a repeated address returns immediately. Misses are served round-robin over the single SDRAM req/ack/data_rdy interface. It sits between the CPU/video ROM users and the SDRAM controller, and also generates `ready` and `refresh_en` for the top level.

Parameters:
SLOTS, 4, number of client slots (1..8)
AW, 22, SDRAM word address width
SAW, 15, per-slot word address width (uniform; upper bits zero-extended)
BASE, {SLOTS{22'd0}}, packed SLOTS*AW vector; slot i SDRAM offset in BASE[i*AW +: AW]
RDY_DLY, 2, cycles from download end to ready assertion (1..15)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active low
downloading  in  1  ROM download in progress; SDRAM owned by loader
slot_cs  in  SLOTS  per-slot read request (level)
slot_addr  in  SLOTS*SAW  per-slot word address, slot i at [i*SAW +: SAW]
slot_dout  out  SLOTS*32  per-slot cached word
slot_ok  out  SLOTS  slot_dout valid for current slot_addr
sdram_req  out  1  fetch request to SDRAM controller
sdram_addr  out  AW  fetch word address
sdram_ack  in  1  controller accepted request
data_rdy  in  1  data_read valid, single cycle
data_read  in  32  SDRAM read data
refresh_en  out  1  controller may refresh now
ready  out  1  ROM contents valid, game may leave reset

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst_n` is synchronous, active low. On reset:
  - all cache valid bits = 0, FSM = IDLE, round-robin pointer = 0;
  - sdram_req = 0, sdram_addr = 0, slot_dout = 0, ready = 0, refresh_en = 1.
- slot_ok[i] (combinational): slot_cs[i] && valid[i] && tag[i]==slot_addr[i]. A hit is seen the same cycle; a hit never touches SDRAM.
- miss[i] = slot_cs[i] && !slot_ok[i] && !(FSM busy serving slot i with latched addr == slot_addr[i]).
- FSM states:
  - IDLE: if any miss, grant the first missing slot at or after ptr (wrapping mod SLOTS). Latch grant index g and addr; sdram_addr <= BASE[g]+addr (AW-bit add, carry dropped); sdram_req <= 1; go to REQ.
  - REQ: hold sdram_req/sdram_addr stable until sdram_ack=1. Then sdram_req <= 0, go to WAIT.
  - WAIT: on data_rdy: data[g] <= data_read, tag[g] <= latched addr, valid[g] <= 1; ptr <= g+1 (wrap); go to IDLE. Earliest slot_ok is the cycle after data_rdy.
- Miss latency = 1 (IDLE->REQ) + ack wait + data wait + 1.
- A slot address change during REQ/WAIT does not abort the fetch. The fetched word is cached under the latched tag; slot_ok stays low for the new address, which misses again in IDLE.
- ack and data_rdy in the same cycle while in REQ: treat as ack then data; store the data and go to IDLE.
- data_rdy seen in IDLE or REQ without a prior ack is ignored.
- refresh_en = 1 only in IDLE with no miss pending.
- downloading=1 (any state):
  - FSM -> IDLE next cycle, sdram_req <= 0, all valid <= 0, ready <= 0;
  - slot_cs is ignored; refresh_en = 0.
- ready: counter loads 0 while downloading or reset. It increments while !downloading; ready <= 1 when count reaches RDY_DLY and then holds.
- SLOTS=1: pointer is constant 0; behaviour is otherwise identical.

Decomposition:
- Shared package jtpopeye_sdram_pkg: FSM state enum (IDLE, REQ, WAIT), slot index width function clog2(SLOTS), default BASE constant.
- One sub-module, jtpopeye_sdram_slot: per-slot cache (valid/tag/data, hit compare, load/clear), instantiated SLOTS times via generate.
- The round-robin arbiter and FSM stay in the top module.

Test Plan:
- Reset then downloading 1->0 with RDY_DLY=2 -> ready=0 for 2 cycles, 1 on the third, refresh_en=1 with no cs.
- Slot0 cs, addr 0x0010, BASE0=0x1000, ack after 3 cycles, data_rdy 0xDEADBEEF 4 cycles later -> sdram_addr=0x001010; slot_ok[0]=1 and slot_dout[0]=0xDEADBEEF the cycle after data_rdy; a second access to 0x0010 gives ok the same cycle with no sdram_req.
- Slots 0,1,2 miss simultaneously, ptr=0 -> grants in order 0,1,2; next round with slots 0 and 2 missing and ptr=3 -> grant 0 then 2.
- Slot1 changes addr 0x05->0x06 during WAIT -> tag 0x05 stored, ok[1] stays 0, new request for 0x06 issued from IDLE.
- downloading pulses high during WAIT -> sdram_req=0 next cycle, all slot_ok=0, ready=0; later data_rdy ignored; after the pulse, refetch occurs.
- ack and data_rdy in the same cycle in REQ -> data stored, FSM back to IDLE, no hang.
